// File: rtl/jac_pkg.sv
// Shared definitions for the JAC core: opcodes, instruction field positions
// and the fetch FSM state type.
package jac_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_LDI  = 4'b0100;
   localparam logic [3:0] OP_LD   = 4'b0101;
   localparam logic [3:0] OP_ST   = 4'b0110;
   localparam logic [3:0] OP_JMP  = 4'b1000;
   localparam logic [3:0] OP_HALT = 4'b1111;

   localparam int unsigned OPC_MSB = 15;
   localparam int unsigned OPC_LSB = 12;

   typedef enum logic [1:0] {
      S_FETCH,
      S_LOAD,
      S_ISSUE,
      S_HALT
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives Program_Mem, resolves JMP/HALT locally and
// hands other instructions to the decoder over a valid/ready handshake.
module fetch_unit
   import jac_pkg::*;
#(
   parameter int unsigned PC_WIDTH   = 8,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned RESET_PC   = 0
) (
   input  logic                  clk,
   input  logic                  res_n,
   output logic [PC_WIDTH-1:0]   pc,
   input  logic [DATA_WIDTH-1:0] ir,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [PC_WIDTH-1:0]   instr_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   input  logic                  branch_en,
   input  logic [PC_WIDTH-1:0]   branch_target,
   output logic                  halted
);

   fetch_state_t state;
   logic [3:0]   opcode;

   assign opcode = ir[OPC_MSB:OPC_LSB];

   always_ff @(posedge clk) begin
      if (!res_n) begin
         state       <= S_FETCH;
         pc          <= PC_WIDTH'(RESET_PC);
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
      end else if (branch_en && state != S_HALT) begin
         // Redirect wins over decode; a same-edge handshake in S_ISSUE is
         // already complete, so dropping valid never loses an accepted word.
         pc          <= branch_target;
         instr_valid <= 1'b0;
         state       <= S_FETCH;
      end else begin
         case (state)
            S_FETCH: state <= S_LOAD;
            S_LOAD: begin
               if (opcode == OP_JMP) begin
                  pc    <= ir[PC_WIDTH-1:0];
                  state <= S_FETCH;
               end else if (opcode == OP_HALT) begin
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else begin
                  instr       <= ir;
                  instr_pc    <= pc;
                  pc          <= pc + PC_WIDTH'(1);
                  instr_valid <= 1'b1;
                  state       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (instr_ready) begin
                  instr_valid <= 1'b0;
                  state       <= S_FETCH;
               end
            end
            S_HALT: state <= S_HALT;
            default: state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed latency/boundary scenarios plus random
// handshake/branch/reset traffic checked against a program-walk model.
module tb_fetch_unit;

   localparam int unsigned PW = 8;
   localparam int unsigned DW = 16;

   logic          clk = 1'b0;
   logic          res_n;
   logic [PW-1:0] pc;
   logic [DW-1:0] ir;
   logic [DW-1:0] instr;
   logic [PW-1:0] instr_pc;
   logic          instr_valid;
   logic          instr_ready;
   logic          branch_en;
   logic [PW-1:0] branch_target;
   logic          halted;

   logic [DW-1:0] mem [256];

   always #5 clk = ~clk;

   // Program_Mem stand-in: synchronous read
   always @(posedge clk) ir <= mem[pc];

   fetch_unit #(
      .PC_WIDTH   (PW),
      .DATA_WIDTH (DW),
      .RESET_PC   (0)
   ) dut (
      .clk           (clk),
      .res_n         (res_n),
      .pc            (pc),
      .ir            (ir),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .branch_en     (branch_en),
      .branch_target (branch_target),
      .halted        (halted)
   );

   int checks = 0;
   int errors = 0;
   int accepts = 0;

   // architectural model: address the program will next execute from
   logic [PW-1:0] exp_pc;
   logic [PW-1:0] p_pc, p_ipc;
   logic [DW-1:0] p_instr;
   logic          p_valid, p_halted;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Walk the program from a: kind 0 = issue at 'at', 1 = halt, 2 = jump loop
   function automatic void resolve(input logic [PW-1:0] a, output int kind, output logic [PW-1:0] at);
      logic [DW-1:0] w;
      kind = 2;
      at   = a;
      for (int i = 0; i < 260; i++) begin
         w = mem[at];
         if (w[15:12] == 4'h8) at = w[PW-1:0];
         else begin
            kind = (w[15:12] == 4'hF) ? 1 : 0;
            return;
         end
      end
   endfunction

   // One clock: apply inputs, step past the edge, check the observed transition
   task automatic cyc(input logic rn, input logic rdy, input logic br, input logic [PW-1:0] tgt);
      int            kind;
      logic [PW-1:0] at;
      p_pc = pc; p_ipc = instr_pc; p_instr = instr; p_valid = instr_valid; p_halted = halted;
      res_n = rn; instr_ready = rdy; branch_en = br; branch_target = tgt;
      @(posedge clk);
      @(negedge clk);
      if (!rn) begin
         chk("rst_valid", instr_valid, 0);
         chk("rst_halted", halted, 0);
         chk("rst_pc", pc, 0);
         chk("rst_instr", instr, 0);
         chk("rst_ipc", instr_pc, 0);
         exp_pc = '0;
      end else if (p_halted === 1'b1) begin
         chk("halt_hold", halted, 1);
         chk("halt_valid", instr_valid, 0);
         chk("halt_pc", pc, p_pc);
      end else begin
         if (p_valid === 1'b1 && rdy) begin
            resolve(exp_pc, kind, at);
            accepts++;
            chk("acc_kind", kind, 0);
            chk("acc_pc", p_ipc, at);
            chk("acc_instr", p_instr, mem[at]);
            exp_pc = p_ipc + 8'd1;
         end
         if (br) begin
            chk("br_valid", instr_valid, 0);
            chk("br_pc", pc, tgt);
            exp_pc = tgt;
         end else begin
            if (p_valid === 1'b1 && !rdy) begin
               chk("stall_valid", instr_valid, 1);
               chk("stall_instr", instr, p_instr);
               chk("stall_ipc", instr_pc, p_ipc);
            end
            if (halted) begin
               resolve(exp_pc, kind, at);
               chk("halt_kind", kind, 1);
               chk("halt_nvalid", instr_valid, 0);
            end
         end
      end
   endtask

   task automatic wait_valid(input logic rdy, output int n);
      n = 0;
      while (!instr_valid && n < 30) begin
         cyc(1'b1, rdy, 1'b0, '0);
         n++;
      end
      chk("wait_timeout", instr_valid, 1);
   endtask

   // Accept the current instruction and count edges until the next one shows
   task automatic next_issue(output int n);
      int w;
      cyc(1'b1, 1'b1, 1'b0, '0);
      chk("drop_valid", instr_valid, 0);
      wait_valid(1'b1, w);
      n = w + 1;
   endtask

   task automatic do_reset();
      cyc(1'b0, 1'b0, 1'b0, '0);
      cyc(1'b0, 1'b0, 1'b0, '0);
   endtask

   initial begin
      int            n;
      logic [3:0]    opc;
      int            r;
      logic          rn, rdy, br;

      res_n = 1'b0; instr_ready = 1'b0; branch_en = 1'b0; branch_target = '0;
      exp_pc = '0;

      // ---- program A: issue latency, stall, jump, branch ----
      for (int i = 0; i < 256; i++) mem[i] = 16'h1100 + 16'(i);
      mem[0] = 16'h4903; mem[1] = 16'h4A14; mem[2] = 16'h4BF0; mem[3] = 16'h0910;
      mem[5] = 16'h480F; mem[8] = 16'h0000; mem[10] = 16'h8008;
      @(negedge clk);
      do_reset();
      cyc(1'b1, 1'b1, 1'b0, '0);
      chk("lat1_valid", instr_valid, 0);
      cyc(1'b1, 1'b1, 1'b0, '0);
      chk("lat2_valid", instr_valid, 1);
      chk("first_instr", instr, 16'h4903);
      chk("first_ipc", instr_pc, 0);
      next_issue(n);
      chk("gap1", n, 3); chk("i1_instr", instr, 16'h4A14); chk("i1_ipc", instr_pc, 1);
      next_issue(n);
      chk("gap2", n, 3); chk("i2_instr", instr, 16'h4BF0); chk("i2_ipc", instr_pc, 2);
      next_issue(n);
      chk("gap3", n, 3); chk("i3_instr", instr, 16'h0910);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 1'b0, 1'b0, '0);
         chk("stall_ipc3", instr_pc, 3);
         chk("stall_pc4", pc, 4);
      end
      for (int i = 4; i < 10; i++) begin
         next_issue(n);
         chk("seq_gap", n, 3);
         chk("seq_ipc", instr_pc, i);
      end
      next_issue(n);
      chk("jmp_gap", n, 5); chk("jmp_ipc", instr_pc, 8); chk("jmp_instr", instr, 16'h0000);
      cyc(1'b1, 1'b1, 1'b1, 8'd5);
      chk("br_drop", instr_valid, 0);
      wait_valid(1'b1, n);
      chk("br_gap", n, 2); chk("br_instr", instr, 16'h480F); chk("br_ipc", instr_pc, 5);

      // ---- program B: HALT at address 2 ----
      for (int i = 0; i < 256; i++) mem[i] = 16'h1234;
      mem[2] = 16'hF000;
      do_reset();
      wait_valid(1'b1, n);
      next_issue(n);
      cyc(1'b1, 1'b1, 1'b0, '0);
      chk("h_pc2", pc, 2);
      cyc(1'b1, 1'b1, 1'b0, '0);
      chk("h_e1", halted, 0);
      cyc(1'b1, 1'b1, 1'b0, '0);
      chk("h_e2", halted, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b1, 1'b1, 8'h77);
         chk("h_brign_pc", pc, 2);
         chk("h_brign_halt", halted, 1);
      end
      cyc(1'b0, 1'b0, 1'b0, '0);
      chk("h_rst_pc", pc, 0);
      chk("h_rst_halt", halted, 0);

      // ---- program C: wrap at 255, reset in S_ISSUE ----
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      do_reset();
      cyc(1'b1, 1'b1, 1'b1, 8'd255);
      chk("w_pc255", pc, 255);
      wait_valid(1'b1, n);
      chk("w_ipc255", instr_pc, 255);
      chk("w_pcwrap", pc, 0);
      next_issue(n);
      chk("w_ipc0", instr_pc, 0);
      chk("w_valid", instr_valid, 1);
      cyc(1'b0, 1'b0, 1'b0, '0);
      chk("w_rst_valid", instr_valid, 0);

      // ---- random program and traffic ----
      for (int i = 0; i < 256; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 8) mem[i] = {4'h8, 4'($urandom), 8'($urandom)};
         else if (r < 10) mem[i] = {4'hF, 12'($urandom)};
         else begin
            opc = 4'($urandom_range(0, 13));
            if (opc >= 4'd8) opc = opc + 4'd1;
            mem[i] = {opc, 12'($urandom)};
         end
      end
      do_reset();
      accepts = 0;
      for (int c = 0; c < 3000; c++) begin
         rn  = ($urandom_range(0, 199) != 0);
         if (halted && $urandom_range(0, 7) == 0) rn = 1'b0;
         rdy = ($urandom_range(0, 9) < 7);
         br  = ($urandom_range(0, 19) == 0);
         cyc(rn, rdy, br, 8'($urandom));
      end
      chk("rand_issued", 32'(accepts > 50), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage; sits directly upstream of Program_Mem and downstream of nothing but reset.
- Drives the `pc` address into Program_Mem and captures the returned `ir` word.
- Resolves unconditional jumps and HALT locally.
- Hands each remaining instruction and its address to the decoder through a valid/ready handshake.
- Multi-cycle design: 3 cycles per issued instruction when the consumer is always ready.

Parameters:
- PC_WIDTH, 8, width of the program counter and of the Program_Mem address.
- DATA_WIDTH, 16, instruction word width.
- RESET_PC, 0, address fetched first after reset.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- res_n  input  1  reset, synchronous, active-low.
- pc  output  PC_WIDTH  fetch address to Program_Mem.
- ir  input  DATA_WIDTH  Program_Mem read data.
- instr  output  DATA_WIDTH  captured instruction to the decoder.
- instr_pc  output  PC_WIDTH  address of `instr`.
- instr_valid  output  1  `instr` and `instr_pc` are valid.
- instr_ready  input  1  decoder accepts `instr` this cycle.
- branch_en  input  1  redirect request from execute.
- branch_target  input  PC_WIDTH  redirect address.
- halted  output  1  HALT fetched; fetch has stopped.

Behaviour:
- Program_Mem contract: synchronous read. `ir` reflects the `pc` value sampled at the previous rising edge.
- Reset: `res_n` low at a rising edge forces:
  - state S_FETCH, `pc` = RESET_PC
  - `instr` = 0, `instr_pc` = 0
  - `instr_valid` = 0, `halted` = 0
  - Reset mid-operation aborts everything identically; an in-flight instruction is dropped.
- Instruction fields: `ir[15:12]` opcode, `ir[PC_WIDTH-1:0]` target/immediate.
- OP_JMP = 4'b1000: consumed in fetch, never issued.
- OP_HALT = 4'b1111: consumed in fetch, never issued.
- S_FETCH:
  - `pc` is stable across the edge; Program_Mem latches the word.
  - Next state S_LOAD.
- S_LOAD (`ir` is valid):
  - OP_JMP: `pc` <= `ir[PC_WIDTH-1:0]`, next S_FETCH, `instr_valid` stays 0.
  - OP_HALT: next S_HALT, `halted` <= 1, `pc` unchanged.
  - Otherwise: `instr` <= `ir`, `instr_pc` <= `pc`, `pc` <= `pc`+1, `instr_valid` <= 1, next S_ISSUE.
- S_ISSUE:
  - Hold `instr`, `instr_pc` and `instr_valid` = 1 stable until `instr_ready` = 1 at an edge.
  - On that edge: `instr_valid` <= 0, next S_FETCH.
  - Without `instr_ready`, stay in S_ISSUE indefinitely.
- S_HALT:
  - Absorbing; only reset exits.
  - `branch_en` is ignored.
  - `instr_valid` = 0, `halted` = 1.
- `branch_en` = 1 in S_FETCH, S_LOAD or S_ISSUE:
  - Highest priority: `pc` <= `branch_target`, `instr_valid` <= 0, next S_FETCH.
  - Overrides jump/HALT decode in S_LOAD.
  - In S_ISSUE, a same-cycle `instr_ready` counts as accepted; the instruction is not re-issued.
- Arithmetic:
  - `pc`+1 is modulo 2^PC_WIDTH (255 -> 0).
  - A jump to the current address is legal and loops forever.
- Latency:
  - First `instr_valid` rises after the 2nd rising edge following reset release.
  - Steady state is one issue per 3 cycles with `instr_ready` tied high.
  - A taken jump costs 2 cycles and issues nothing.

Decomposition:
- Shared package `jac_pkg`: opcode constants (OP_JMP, OP_HALT, plus the existing ALU/load opcodes), instruction field positions, and the fetch state encodings.
- No sub-module: the FSM, PC register and instruction register form one block.
- Top level instantiates fetch_unit alongside Program_Mem.

Test Plan:
- Reset then `instr_ready` = 1:
  - `instr` = 0x4903, `instr_pc` = 0 with `instr_valid` high after the 2nd edge.
  - Then 0x4A14 @1 and 0x4BF0 @2, each 3 cycles apart.
- `instr_ready` = 0 for 5 cycles on the 0x0910 @3 issue:
  - `instr`, `instr_pc` and `instr_valid` stay stable.
  - `pc` = 4 throughout.
  - Exactly one issue once ready.
- Run to pc 10 (0x8008):
  - No issue for pc 10; next fetch `pc` = 8; next issue `instr_pc` = 8, `instr` = 0x0000.
- `branch_en` = 1, `branch_target` = 5 during S_ISSUE with `instr_ready` = 1:
  - `instr_valid` drops; next issue is 0x480F @5; the squashed instruction does not reappear.
- Memory word 0xF000 at pc 2:
  - `halted` = 1 two edges after `pc` = 2.
  - `branch_en` is then ignored.
  - Reset restores `pc` = 0, `halted` = 0.
- Program of 0x0000 words with `pc` at 255:
  - Next `pc` = 0.
  - `res_n` pulsed low mid-S_ISSUE clears `instr_valid` at that edge.
